// File: rtl/wb_retire_queue_pkg.sv
// Shared widths and sizing helpers for the writeback retire queue.
// to_WB_data is packed {pc, dest, final_result, gr_we} with pc in the MSBs.
package wb_retire_queue_pkg;

  localparam int WB_PC_W      = 32;
  localparam int WB_ADDR_W    = 5;
  localparam int WB_DATA_W    = 32;
  localparam int TO_WB_DATA_W = WB_PC_W + WB_ADDR_W + WB_DATA_W + 1;

  function automatic int fifo_ptr_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  function automatic int fifo_cnt_w(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/wb_retire_queue_fifo.sv
// Generic synchronous FIFO with clear, head view and a flat view of every slot
// plus per-slot valid bits, so the parent can scan all queued entries.
module wb_fifo
  import wb_retire_queue_pkg::*;
#(
  parameter int WIDTH = TO_WB_DATA_W,
  parameter int DEPTH = 2
) (
  input  logic                           clk,
  input  logic                           resetn,
  input  logic                           i_push,
  input  logic                           i_pop,
  input  logic                           i_clear,
  input  logic [WIDTH-1:0]               i_data,
  output logic [fifo_cnt_w(DEPTH)-1:0]   o_count,
  output logic [WIDTH-1:0]               o_head,
  output logic [WIDTH*DEPTH-1:0]         o_entries,
  output logic [DEPTH-1:0]               o_valid
);

  localparam int PTR_W  = fifo_ptr_w(DEPTH);
  localparam int CNT_FW = fifo_cnt_w(DEPTH);

  logic [WIDTH-1:0]  r_mem [DEPTH];
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [CNT_FW-1:0] r_count;
  logic [DEPTH-1:0]  r_valid;
  logic [DEPTH-1:0]  w_valid_nxt;

  // Explicit compare-and-reset keeps non-power-of-two depths correct.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    if (p == PTR_W'(DEPTH - 1)) return '0;
    return p + PTR_W'(1);
  endfunction

  // Clear before set: a push into the slot popped this cycle stays valid.
  always_comb begin
    w_valid_nxt = r_valid;
    if (i_pop)  w_valid_nxt[r_rd_ptr] = 1'b0;
    if (i_push) w_valid_nxt[r_wr_ptr] = 1'b1;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_valid  <= '0;
    end else if (i_clear) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_valid  <= '0;
    end else begin
      if (i_push) r_wr_ptr <= ptr_inc(r_wr_ptr);
      if (i_pop)  r_rd_ptr <= ptr_inc(r_rd_ptr);
      case ({i_push, i_pop})
        2'b10:   r_count <= r_count + CNT_FW'(1);
        2'b01:   r_count <= r_count - CNT_FW'(1);
        default: r_count <= r_count;
      endcase
      r_valid <= w_valid_nxt;
    end
  end

  // Payload storage carries no reset; valid bits qualify every read.
  always_ff @(posedge clk) begin
    if (i_push) r_mem[r_wr_ptr] <= i_data;
  end

  for (genvar g = 0; g < DEPTH; g++) begin : g_flat
    assign o_entries[g*WIDTH +: WIDTH] = r_mem[g];
  end

  assign o_count = r_count;
  assign o_head  = r_mem[r_rd_ptr];
  assign o_valid = r_valid;

endmodule

// File: rtl/wb_retire_queue.sv
// Writeback stage with a DEPTH-entry retire queue: drains one instruction per
// cycle to the register file and exports a pending-write scoreboard for ID.
module wb_retire_queue
  import wb_retire_queue_pkg::*;
#(
  parameter int DATA_W = WB_DATA_W,
  parameter int ADDR_W = WB_ADDR_W,
  parameter int PC_W   = WB_PC_W,
  parameter int DEPTH  = 2,
  parameter int CNT_W  = 32
) (
  input  logic                            clk,
  input  logic                            resetn,
  input  logic [PC_W+ADDR_W+DATA_W:0]     to_WB_data,
  input  logic                            MEM_to_WB_valid,
  output logic                            WB_allow_in,
  input  logic                            flush,
  input  logic                            rf_wr_ready,
  output logic                            rf_we,
  output logic [ADDR_W-1:0]               rf_waddr,
  output logic [DATA_W-1:0]               rf_wdata,
  output logic [2**ADDR_W-1:0]            wb_pending,
  output logic [PC_W-1:0]                 debug_wb_pc,
  output logic [3:0]                      debug_wb_rf_we,
  output logic [ADDR_W-1:0]               debug_wb_rf_wnum,
  output logic [DATA_W-1:0]               debug_wb_rf_wdata,
  output logic [CNT_W-1:0]                retired_cnt
);

  localparam int ENTRY_W = PC_W + ADDR_W + DATA_W + 1;
  localparam int CNT_FW  = fifo_cnt_w(DEPTH);

  logic [CNT_FW-1:0]        w_count;
  logic [ENTRY_W-1:0]       w_head;
  logic [ENTRY_W*DEPTH-1:0] w_entries;
  logic [DEPTH-1:0]         w_valid;
  logic                     w_empty;
  logic                     w_full;
  logic                     w_push;
  logic                     w_retire;
  logic                     w_need_port;
  logic [PC_W-1:0]          w_head_pc;
  logic [ADDR_W-1:0]        w_head_dest;
  logic [DATA_W-1:0]        w_head_data;
  logic                     w_head_we;
  logic [2**ADDR_W-1:0]     w_pending;
  logic [ENTRY_W-1:0]       w_scan;
  logic [CNT_W-1:0]         r_retired_cnt;

  wb_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .resetn    (resetn),
    .i_push    (w_push),
    .i_pop     (w_retire),
    .i_clear   (flush),
    .i_data    (to_WB_data),
    .o_count   (w_count),
    .o_head    (w_head),
    .o_entries (w_entries),
    .o_valid   (w_valid)
  );

  assign w_head_pc   = w_head[ENTRY_W-1 -: PC_W];
  assign w_head_dest = w_head[ADDR_W+DATA_W : DATA_W+1];
  assign w_head_data = w_head[DATA_W:1];
  assign w_head_we   = w_head[0];

  assign w_empty     = (w_count == '0);
  assign w_full      = (w_count == CNT_FW'(DEPTH));
  assign w_need_port = w_head_we && (w_head_dest != '0);

  // Writes to r0 or non-writing instructions retire without the port.
  assign w_retire    = !w_empty && !flush && (!w_need_port || rf_wr_ready);
  assign WB_allow_in = !w_full || w_retire;
  assign w_push      = MEM_to_WB_valid && WB_allow_in && !flush;

  assign rf_we    = w_retire && w_need_port;
  assign rf_waddr = w_empty ? '0 : w_head_dest;
  assign rf_wdata = w_empty ? '0 : w_head_data;

  // Scoreboard covers queued entries only, never this cycle's push.
  always_comb begin
    w_pending = '0;
    w_scan    = '0;
    for (int i = 0; i < DEPTH; i++) begin
      w_scan = w_entries[i*ENTRY_W +: ENTRY_W];
      if (w_valid[i] && w_scan[0] && (w_scan[ADDR_W+DATA_W : DATA_W+1] != '0))
        w_pending[w_scan[ADDR_W+DATA_W : DATA_W+1]] = 1'b1;
    end
  end
  assign wb_pending = w_pending;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)       r_retired_cnt <= '0;
    else if (w_retire) r_retired_cnt <= r_retired_cnt + CNT_W'(1);
  end
  assign retired_cnt = r_retired_cnt;

  assign debug_wb_pc       = w_retire ? w_head_pc : '0;
  assign debug_wb_rf_we    = {4{rf_we}};
  assign debug_wb_rf_wnum  = rf_waddr;
  assign debug_wb_rf_wdata = rf_wdata;

endmodule

// File: doc/wb_retire_queue.md
# wb_retire_queue

Parametrised writeback stage for the in-order pipeline. It replaces the single-slot WB register with a DEPTH-entry retire queue, so a MEM result is accepted even when the register-file write port is held by another writer (divider, CSR unit). It drains one instruction per cycle to the register file. It also exports a pending-write scoreboard for ID hazard checks, a debug retire trace and a retired-instruction counter.

## Interface
- DATA_W, 32, register data width
- ADDR_W, 5, register index width; register 0 is hard-wired zero
- PC_W, 32, instruction address width
- DEPTH, 2, retire queue entries (≥1)
- CNT_W, 32, retired-instruction counter width
- clk  in  1  clock; the only clock
- resetn  in  1  asynchronous active-low reset
- to_WB_data  in  PC_W+ADDR_W+DATA_W+1  packed {pc, dest, final_result, gr_we}, pc in the MSBs
- MEM_to_WB_valid  in  1  upstream payload valid
- WB_allow_in  out  1  stage can accept this cycle
- flush  in  1  discard all queued, unretired entries
- rf_wr_ready  in  1  register-file write port granted to WB this cycle
- rf_we  out  1  register write enable
- rf_waddr  out  ADDR_W  write index
- rf_wdata  out  DATA_W  write data
- wb_pending  out  2**ADDR_W  bit r set when a queued entry will write register r
- debug_wb_pc  out  PC_W  pc of the instruction retiring this cycle
- debug_wb_rf_we  out  4  {4{rf_we}}
- debug_wb_rf_wnum  out  ADDR_W  equals rf_waddr
- debug_wb_rf_wdata  out  DATA_W  equals rf_wdata
- retired_cnt  out  CNT_W  instructions retired since reset

## Operation
- **Queue.** A FIFO of DEPTH entries with an occupancy count 0..DEPTH. The head is the oldest entry.
- **Push.** A push occurs when MEM_to_WB_valid && WB_allow_in && !flush. WB_allow_in = (count < DEPTH) || retire.
- **Port need.** The head needs the write port iff gr_we && dest != 0.
- **Retire.** The head retires when the queue is non-empty, !flush, and either it needs no port or rf_wr_ready is high. Retire pops the head.
- **Register-file write.** rf_we = retire && head needs the port. rf_waddr and rf_wdata always present the head's dest and result, or 0 when the queue is empty.
- **Zero-register suppression.** A retiring instruction with dest==0 or gr_we==0 still retires, still appears on debug_wb_pc, and still increments retired_cnt, but drives rf_we = 0.
- **Scoreboard.** wb_pending is an OR over valid entries with gr_we && dest != 0. It is combinational from queue state only, not from this cycle's push. Bit 0 is always 0.
- **Flush.** Clears count to 0. It blocks retire and push in the same cycle, so rf_we = 0 and retired_cnt holds. Upstream valid during a flush is dropped.
- **Counter.** retired_cnt increments by 1 per retire and wraps modulo 2**CNT_W.
- **Debug pc.** debug_wb_pc is the head pc when retire is high, else 0.

## Timing
- **Reset.** Asynchronous on resetn low: count=0, pointers=0, retired_cnt=0. All outputs read 0, except WB_allow_in = 1.
- **Latency.** An entry pushed at edge t can retire in the cycle after edge t. Minimum latency is 1 cycle, matching the single-register stage.
- **Throughput.** One instruction per cycle with rf_wr_ready held high and DEPTH ≥ 1. Push and retire in the same cycle on a full queue is legal; the count is unchanged.
- **Combinational paths.** WB_allow_in, rf_we and debug outputs depend combinationally on rf_wr_ready and flush. There is no path from MEM_to_WB_valid to WB_allow_in.
- **Pointers.** Read and write pointers wrap modulo DEPTH. A non-power-of-two DEPTH uses explicit compare-and-reset.
- **Reset mid-operation.** Queued entries are lost without a register-file write.

## Structure
- **constants.h.** Add `WB_PC_W`, `WB_ADDR_W` and `WB_DATA_W`. `to_WB_data_width` is redefined as their sum + 1 so MEM_stage packs the same field order.
- **wb_fifo.** One sub-module, a generic synchronous FIFO parametrised by WIDTH and DEPTH. It has an asynchronous active-low reset and exposes push, pop, clear, count and head. It also exposes a flat vector of all entries plus valid bits, which the scoreboard uses.
- **Top level.** Retire logic, scoreboard OR-reduction, counter and debug outputs live in wb_retire_queue.

## Test plan
- **Reset and idle.** Hold resetn low, then release with no valid input. All outputs are 0, WB_allow_in = 1, retired_cnt = 0.
- **Back-to-back retire.** Push pc 0x1c000000/dest 5/data 0xDEADBEEF, then pc 0x1c000004/dest 6/data 1, with rf_wr_ready = 1. rf_we is high in consecutive cycles with waddr 5 then 6, and retired_cnt = 2.
- **Port stall.** With DEPTH=2 and rf_wr_ready = 0, push three writes to r3, r4, r7. The third is held because WB_allow_in = 0, and wb_pending = bits 3 and 4. Raise rf_wr_ready: r3 retires, r7 is accepted in the same cycle, and the sequence continues in order.
- **Zero register and no-write.** Push dest 0 with gr_we = 1, then dest 9 with gr_we = 0, with rf_wr_ready = 0. Both retire on successive cycles with rf_we = 0, debug_wb_pc shows both pcs, and retired_cnt increments by 2.
- **Flush.** Fill the queue (r10, r11), assert flush together with MEM_to_WB_valid. The next cycle count = 0, wb_pending = 0, and no rf_we fires for r10, r11 or the new entry.
- **Counter wrap and async reset.** With CNT_W=4, retire 17 instructions so retired_cnt = 1. Then drop resetn between clock edges with entries queued: outputs clear immediately and no write occurs.
